gray_counter: RTL and testbench

Parameterised N-bit counter whose state is held in binary and is also presented as a registered Gray-code output. Each count step changes exactly one Gray bit, so the Gray value can be sampled safely from another clock domain. It is the encode-side complement of the team's Gray-to-binary decoding and is intended as the pointer source for asynchronous FIFOs and multi-domain position counters. It supports enable, synchronous clear, parallel binary load and a wrap pulse.

---
 rtl/gray_counter_pkg.sv | 14 +
 rtl/gray_counter_binary_to_gray.sv | 14 +
 rtl/gray_counter.sv | 68 ++++++
 tb/tb_gray_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gray_counter_pkg.sv
// Shared width constants and the binary-to-Gray encoding for counters and FIFO pointers.
// No latency (package only); no flow control.
package gray_counter_pkg;

    localparam int GRAY_COUNTER_N_DEFAULT = 4;
    localparam int GRAY_COUNTER_N_MIN     = 2;
    localparam int GRAY_W_MAX             = 32;

    // Callers zero-extend into the wide argument and truncate the result to their own width.
    function automatic logic [GRAY_W_MAX-1:0] bin_to_gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_binary_to_gray.sv
// Combinational N-bit binary-to-Gray encoder.
// Zero latency; no flow control.
module binary_to_gray
    import gray_counter_pkg::*;
#(
    parameter int N = GRAY_COUNTER_N_DEFAULT
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = N'(bin_to_gray(GRAY_W_MAX'(bin)));

endmodule

// File: rtl/gray_counter.sv
// N-bit binary counter with registered Gray output and rollover pulse; `GRAY_COUNTER_DOWN_EN adds dn.
// One-cycle latency from inputs to bin/gray/wrap; no backpressure, en simply stalls the count.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int N = GRAY_COUNTER_N_DEFAULT  // must be >= GRAY_COUNTER_N_MIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_bin,
`ifdef GRAY_COUNTER_DOWN_EN
    input  logic         dn,
`endif
    output logic [N-1:0] bin,
    output logic [N-1:0] gray,
    output logic         wrap
);

    logic [N-1:0] bin_nxt;
    logic [N-1:0] gray_nxt;
    logic         wrap_nxt;

    // Priority: clear, then load, then count; only a count step can raise wrap.
    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (clr) begin
            bin_nxt = '0;
        end else if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
`ifdef GRAY_COUNTER_DOWN_EN
            if (dn) begin
                bin_nxt  = bin - 1'b1;
                wrap_nxt = (bin == '0);
            end else begin
                bin_nxt  = bin + 1'b1;
                wrap_nxt = &bin;
            end
`else
            bin_nxt  = bin + 1'b1;
            wrap_nxt = &bin;
`endif
        end
    end

    // Encode the next value so gray is a flop output, glitch-free for other clock domains.
    binary_to_gray #(.N(N)) u_b2g (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Directed checks of gray_counter at N=4 with hand-computed expectations.
module tb_gray_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_bin = '0;
    logic         dn = 1'b0;
    logic [N-1:0] bin;
    logic [N-1:0] gray;
    logic         wrap;

    int vectors = 0;
    int miscompares = 0;

    gray_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_bin (load_bin),
`ifdef GRAY_COUNTER_DOWN_EN
        .dn       (dn),
`endif
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [N-1:0] v);
        load     = 1'b1;
        load_bin = v;
        en       = 1'b0;
        tick();
        load     = 1'b0;
    endtask

    logic [N-1:0] exp_gray [0:16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    logic [N-1:0] prev_gray;

    initial begin
        dn = 1'b0;
        tick();
        tick();
        chk("rst_bin", bin, 0);
        chk("rst_gray", gray, 0);
        chk("rst_wrap", wrap, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a cycle at bin = 9
        do_load(4'd9);
        chk("load9_bin", bin, 9);
        chk("load9_gray", gray, 13);
        #2 rst = 1'b1;
        #1;
        chk("arst_bin", bin, 0);
        chk("arst_gray", gray, 0);
        chk("arst_wrap", wrap, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset drops a pending wrap pulse
        do_load(4'd15);
        en = 1'b1;
        tick();
        chk("wrap_pend", wrap, 1);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_wrap_drop", wrap, 0);
        chk("arst_bin2", bin, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full up sweep from 0
        chk("sweep_gray_0", gray, exp_gray[0]);
        prev_gray = gray;
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("sweep_gray_%0d", i), gray, exp_gray[i]);
            chk($sformatf("sweep_bin_%0d", i), bin, i % 16);
            chk($sformatf("sweep_1bit_%0d", i), $countones(gray ^ prev_gray), 1);
            chk($sformatf("sweep_wrap_%0d", i), wrap, (i == 16) ? 1 : 0);
            prev_gray = gray;
        end

        // Load beats enable; clear beats load
        load = 1'b1; load_bin = 4'd10; en = 1'b1;
        tick();
        chk("ld_en_bin", bin, 10);
        chk("ld_en_gray", gray, 15);
        chk("ld_en_wrap", wrap, 0);
        clr = 1'b1;
        tick();
        chk("clr_ld_bin", bin, 0);
        chk("clr_ld_gray", gray, 0);
        clr = 1'b0; load = 1'b0; en = 1'b0;

        // Clear with enable at 15 gives no wrap
        do_load(4'd15);
        clr = 1'b1; en = 1'b1;
        tick();
        chk("clr_en15_bin", bin, 0);
        chk("clr_en15_wrap", wrap, 0);
        clr = 1'b0; en = 1'b0;

        // Hold at 6
        do_load(4'd6);
        for (int i = 0; i < 5; i++) begin
            load_bin = 4'd3;
            tick();
            chk($sformatf("hold_bin_%0d", i), bin, 6);
            chk($sformatf("hold_gray_%0d", i), gray, 5);
            chk($sformatf("hold_wrap_%0d", i), wrap, 0);
        end

        // Load across the boundary, 15 -> 0
        do_load(4'd15);
        load = 1'b1; load_bin = 4'd0; en = 1'b1;
        tick();
        chk("ldx_bin", bin, 0);
        chk("ldx_wrap", wrap, 0);

        // load_bin ignored while counting
        load = 1'b0; load_bin = 4'd12;
        tick();
        chk("ign_ldbin_bin", bin, 1);
        chk("ign_ldbin_gray", gray, 1);
        en = 1'b0;

`ifdef GRAY_COUNTER_DOWN_EN
        do_load(4'd1);
        dn = 1'b1; en = 1'b1;
        tick();
        chk("dn_bin0", bin, 0);
        chk("dn_gray0", gray, 0);
        chk("dn_wrap0", wrap, 0);
        tick();
        chk("dn_bin15", bin, 15);
        chk("dn_gray15", gray, 8);
        chk("dn_wrap15", wrap, 1);
        tick();
        chk("dn_bin14", bin, 14);
        chk("dn_gray14", gray, 9);
        chk("dn_wrap14", wrap, 0);
        dn = 1'b0; en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
